// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph encodings,
// FSM states, default settle time and anode helpers.
package ssd_pkg;

  localparam int unsigned SSD_SETTLE_CYCLES = 16;

  // Active-low cathode patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] BLANK_GLYPH = 7'h7F;
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } ssd_state_e;

  // A scan slot is only meaningful when exactly one digit enable is low.
  function automatic logic anode_legal(input logic [3:0] anode);
    logic legal;
    case (anode)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [1:0] anode_pos(input logic [3:0] anode);
    logic [1:0] pos;
    case (anode)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Display pin bundle plus recovered digit state. SSD_DP_CAPTURE_EN adds the
// decimal-point pin and its per-position capture.
interface ssd_scan_decoder_if;

  logic [3:0]  anode_in;
  logic [6:0]  cathode_in;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        frame_strobe;
  logic        glyph_error;
  logic        scan_timeout;
`ifdef SSD_DP_CAPTURE_EN
  logic        dp_in;
  logic [3:0]  dp_out;
`endif

  // Display driver side: drives the pins, observes the decode results.
  modport master (
`ifdef SSD_DP_CAPTURE_EN
    output dp_in,
    input  dp_out,
`endif
    output anode_in,
    output cathode_in,
    input  digits,
    input  digit_valid,
    input  frame_valid,
    input  frame_strobe,
    input  glyph_error,
    input  scan_timeout
  );

  // Decoder side.
  modport slave (
`ifdef SSD_DP_CAPTURE_EN
    input  dp_in,
    output dp_out,
`endif
    input  anode_in,
    input  cathode_in,
    output digits,
    output digit_valid,
    output frame_valid,
    output frame_strobe,
    output glyph_error,
    output scan_timeout
  );

endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational cathode-pattern to hex lookup; flags blank and unknown patterns.
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] cathode,
  output logic       hit,
  output logic       blank,
  output logic [3:0] hex
);

  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    hex   = 4'h0;
    case (cathode)
      GLYPH_0:     hex = 4'h0;
      GLYPH_1:     hex = 4'h1;
      GLYPH_2:     hex = 4'h2;
      GLYPH_3:     hex = 4'h3;
      GLYPH_4:     hex = 4'h4;
      GLYPH_5:     hex = 4'h5;
      GLYPH_6:     hex = 4'h6;
      GLYPH_7:     hex = 4'h7;
      GLYPH_8:     hex = 4'h8;
      GLYPH_9:     hex = 4'h9;
      GLYPH_A:     hex = 4'hA;
      GLYPH_B:     hex = 4'hB;
      GLYPH_C:     hex = 4'hC;
      GLYPH_D:     hex = 4'hD;
      GLYPH_E:     hex = 4'hE;
      GLYPH_F:     hex = 4'hF;
      BLANK_GLYPH: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default:     hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Recovers four hex digits from a multiplexed seven-segment scan waveform.
// Optional SSD_DP_CAPTURE_EN also captures the decimal point per position.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = SSD_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic               clk,
  input logic               reset,
  ssd_scan_decoder_if.slave bus
);

`ifdef SSD_DP_CAPTURE_EN
  localparam int unsigned PIN_W = 12;
`else
  localparam int unsigned PIN_W = 11;
`endif
  localparam int unsigned SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

  logic [PIN_W-1:0] pins_s;
  logic [PIN_W-1:0] sync1_q, sync2_q, prev_q;
  logic [3:0]       anode_s;
  logic [6:0]       cathode_s;
  logic             stable_s, legal_s, capture_s;
  logic [1:0]       pos_s;
  logic             hit_s, blank_s;
  logic [3:0]       hex_s;

  ssd_state_e       state_q, state_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       seen_q, seen_d, seen_next_s;
  logic             fvalid_q, fvalid_d;
  logic             strobe_q, strobe_d;
  logic             gerr_q, gerr_d;
  logic             timeout_q, timeout_d;
`ifdef SSD_DP_CAPTURE_EN
  logic [3:0]       dp_q, dp_d;

  assign pins_s = {bus.dp_in, bus.anode_in, bus.cathode_in};
`else
  assign pins_s = {bus.anode_in, bus.cathode_in};
`endif

  assign anode_s   = sync2_q[10:7];
  assign cathode_s = sync2_q[6:0];
  assign stable_s  = (sync2_q == prev_q);
  assign legal_s   = anode_legal(anode_s);
  assign pos_s     = anode_pos(anode_s);

  ssd_glyph_decode u_decode (
    .cathode (cathode_s),
    .hit     (hit_s),
    .blank   (blank_s),
    .hex     (hex_s)
  );

  // Pin synchronizer; idle display pins are high, so flops reset to ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= {PIN_W{1'b1}};
      sync2_q <= {PIN_W{1'b1}};
      prev_q  <= {PIN_W{1'b1}};
    end else begin
      sync1_q <= pins_s;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Scan FSM: wait for a legal slot, require SETTLE_CYCLES of stability, capture once.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_s) begin
          state_d      = SETTLE;
          settle_cnt_d = {SW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (!legal_s) begin
          state_d      = IDLE;
          settle_cnt_d = {SW{1'b0}};
        end else if (!stable_s) begin
          settle_cnt_d = {SW{1'b0}};
        end else if (settle_cnt_q == SETTLE_LAST) begin
          capture_s    = 1'b1;
          state_d      = CAPTURED;
          settle_cnt_d = {SW{1'b0}};
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      CAPTURED: begin
        if (stable_s) begin
          state_d = CAPTURED;
        end else if (legal_s) begin
          state_d      = SETTLE;
          settle_cnt_d = {SW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        settle_cnt_d = {SW{1'b0}};
      end
    endcase
  end

  // Capture datapath, frame tracking and scan-loss timeout; capture beats expiry.
  always_comb begin
    digits_d    = digits_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    strobe_d    = 1'b0;
    gerr_d      = 1'b0;
    to_cnt_d    = to_cnt_q;
    timeout_d   = timeout_q;
    seen_next_s = seen_q | (4'b0001 << pos_s);
`ifdef SSD_DP_CAPTURE_EN
    dp_d        = dp_q;
`endif
    if (capture_s) begin
      if (hit_s) begin
        digits_d[{pos_s, 2'b00} +: 4] = hex_s;
        valid_d[pos_s]                = 1'b1;
      end else begin
        valid_d[pos_s] = 1'b0;
        gerr_d         = !blank_s;
      end
      if (seen_next_s == 4'b1111) begin
        strobe_d = 1'b1;
        seen_d   = 4'b0000;
      end else begin
        seen_d = seen_next_s;
      end
`ifdef SSD_DP_CAPTURE_EN
      dp_d[pos_s] = ~sync2_q[11];
`endif
      to_cnt_d  = {TW{1'b0}};
      timeout_d = 1'b0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_q == TO_LAST) begin
        timeout_d = 1'b1;
        valid_d   = 4'b0000;
        seen_d    = 4'b0000;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      to_cnt_d = TO_MAX;
    end
    fvalid_d = &valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= {SW{1'b0}};
      to_cnt_q     <= {TW{1'b0}};
      digits_q     <= 16'h0000;
      valid_q      <= 4'b0000;
      seen_q       <= 4'b0000;
      fvalid_q     <= 1'b0;
      strobe_q     <= 1'b0;
      gerr_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef SSD_DP_CAPTURE_EN
      dp_q         <= 4'b0000;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      fvalid_q     <= fvalid_d;
      strobe_q     <= strobe_d;
      gerr_q       <= gerr_d;
      timeout_q    <= timeout_d;
`ifdef SSD_DP_CAPTURE_EN
      dp_q         <= dp_d;
`endif
    end
  end

  assign bus.digits       = digits_q;
  assign bus.digit_valid  = valid_q;
  assign bus.frame_valid  = fvalid_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.glyph_error  = gerr_q;
  assign bus.scan_timeout = timeout_q;
`ifdef SSD_DP_CAPTURE_EN
  assign bus.dp_out       = dp_q;
`endif

endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Captures the time-multiplexed anode/cathode drive of a 4-digit seven-segment display and reconstructs the four hex digits being shown. It is the receiving end of the display scan interface. It sits on a board input header or loopback path to check, log or mirror what a display driver presents. The block recovers digit values, per-digit validity, frame completion and scan loss, all from the pin-level waveform alone.

## Interface
- SETTLE_CYCLES, 16: cycles anode+cathode must hold unchanged before a sample is taken (≥2)
- TIMEOUT_CYCLES, 1000000: cycles without any capture before scan loss is flagged
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- anode_in  input  4  digit enables, active low, bit n = digit position n
- cathode_in  input  7  segments, active low, {g,f,e,d,c,b,a}
- digits  output  16  recovered digits, [4n+3:4n] = position n
- digit_valid  output  4  bit n set = position n holds a decoded glyph
- frame_valid  output  1  &digit_valid
- frame_strobe  output  1  one-cycle pulse when all four positions captured since last strobe
- glyph_error  output  1  one-cycle pulse on capture of an unrecognised non-blank pattern
- scan_timeout  output  1  level, scan lost

## Operation
- anode_in and cathode_in pass through a two-flop synchronizer. All logic below uses the synchronized values.
- An anode is legal only when exactly one bit is low. 0000, 1111 and multi-low patterns are "no digit".
- FSM states: IDLE, SETTLE, CAPTURED.
  - IDLE: on a legal anode → SETTLE, with the settle counter at 0.
  - SETTLE: the counter increments while {anode,cathode} equals the previous cycle's value. Any change restarts the counter and stays in SETTLE. An illegal anode → IDLE. When the counter reaches SETTLE_CYCLES-1 → capture, then CAPTURED.
  - CAPTURED: hold with no further captures while inputs are unchanged. Any change → SETTLE if the anode is legal, otherwise IDLE.
- Capture at position n:
  - Glyph hit: write digits[n] and set digit_valid[n].
  - Cathode 7'h7F (blank): clear digit_valid[n] and leave digits[n] unchanged. No error.
  - Other miss: pulse glyph_error, clear digit_valid[n] and leave digits[n] unchanged.
  - In all cases, set seen[n].
- Glyph table (hex → cathode): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Frame: when seen becomes 4'b1111, pulse frame_strobe and clear seen on the same edge. Recapturing a position before the frame completes does not strobe.
- Timeout: the counter resets on every capture and otherwise saturates. At TIMEOUT_CYCLES it sets scan_timeout and clears digit_valid and seen. The next capture clears scan_timeout.

## Timing
- Reset values:
  - digits = 0, digit_valid = 0, frame_valid = 0, frame_strobe = 0, glyph_error = 0, scan_timeout = 0.
  - seen = 0, state = IDLE, all counters 0, synchronizer flops = 1 (pins idle high).
- Capture latency: outputs update on the (SETTLE_CYCLES+2)th rising edge after a pin change that is then held stable.
- frame_strobe and glyph_error assert on the same edge as the capture that causes them.
- If a capture and timeout expiry fall on the same cycle, the capture wins: no timeout, and the counter is cleared.
- A glitch shorter than SETTLE_CYCLES causes no capture. If it occurs in CAPTURED, it forces a re-settle and a later recapture of the same position.
- Reset asserted mid-frame clears everything immediately. The first frame after reset needs four fresh captures.

## Configuration
- SSD_DP_CAPTURE_EN
  - Defined: adds input dp_in (1, active low) to the synchronizer and the stability compare, and adds output dp_out (4). On capture, dp_out[n] = ~dp_in. dp_out resets to 0.
  - Undefined: neither port exists, and the decimal point has no effect on stability or capture.

## Structure
- Package ssd_pkg: the 16 glyph constants, BLANK_GLYPH = 7'h7F, state enum (IDLE/SETTLE/CAPTURED), and the default SETTLE_CYCLES.
- Sub-module ssd_glyph_decode: combinational cathode[6:0] → {hit, blank, hex[3:0]}.

## Test plan
- Drive anode 1110 with cathode 24 for 20 cycles → digits[3:0]=2 and digit_valid=0001 at edge SETTLE_CYCLES+2. No strobe.
- Scan "1A3F" on positions 0..3, 50 cycles per digit → frame_strobe one pulse after position 3, digits=16'hF3A1, frame_valid=1.
- Hold position 1 with cathode 7F → digit_valid[1] clears with no glyph_error. Cathode 7E → glyph_error pulse, digit_valid[1]=0, digits[7:4] unchanged.
- A 5-cycle cathode glitch during a 16-cycle settle → no capture until 16 stable cycles follow. An anode of 1100 → IDLE, no capture.
- Stop scanning after a full frame → scan_timeout=1 and digit_valid=0 after TIMEOUT_CYCLES. The next capture clears scan_timeout.
- Assert reset mid-frame → all outputs 0 asynchronously. With SSD_DP_CAPTURE_EN, dp_in=0 on position 2 → dp_out=0100.
